// File: rtl/alu_driver.sv
// ALU initiator: takes requests on a valid/ready stream, holds each on the ALU for a
// fixed settle interval, then returns the sampled result through a show-ahead FIFO.
module alu_driver #(
  parameter int DATA_WIDTH    = 32,
  parameter int OP_WIDTH      = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_r,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OP_WIDTH-1:0]   rsp_op,
  output logic [DATA_WIDTH-1:0] rsp_r,
  output logic                  busy,
  output logic [15:0]           issued_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = OP_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] DEPTH       = CW'(FIFO_DEPTH);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t        state, state_next;
  logic [3:0]    settle_cnt;
  logic          settle_done, accept, push, pop;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] last_pop;

  assign settle_done = (settle_cnt == 4'd0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting every output at the top of a comb block prevents latch inference.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (accept)      state_next = SETTLE;
      SETTLE: if (settle_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Accepting only while the FIFO has room guarantees the end-of-settle push never overflows.
  always_comb begin
    req_ready = (state == IDLE) && (count < DEPTH) && !rst;
    busy      = (state == SETTLE);
    accept    = req_valid && req_ready;
    push      = (state == SETTLE) && settle_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      settle_cnt <= '0;
      issued_cnt <= '0;
    end else if (accept) begin
      alu_op     <= req_op;
      alu_a      <= req_a;
      alu_b      <= req_b;
      settle_cnt <= SETTLE_LOAD;
      issued_cnt <= issued_cnt + 16'd1;
    end else if ((state == SETTLE) && !settle_done) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_pop <= '0;
    end else begin
      assert (!(push && !pop && (count == DEPTH)));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        last_pop <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is left unreset; an entry is only visible after it has been written.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {alu_op, alu_r};
  end

  // Head while non-empty, otherwise the most recently popped entry.
  assign {rsp_op, rsp_r} = rsp_valid ? mem[rd_ptr] : last_pop;

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator for the ALU port group `op`/`a`/`b`/`r`: it drives operands and opcode into the combinational ALU and samples the result.
- Accepts operation requests on a valid/ready stream and applies each to the ALU for a fixed settle interval.
- Captures the ALU result and returns it, tagged with its opcode, through a small response FIFO.
- Sits between the bench sequencer (or a datapath controller) and the ALU wrapper.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- OP_WIDTH, 4, opcode width; opcodes are opaque to this block.
- SETTLE_CYCLES, 2, clock edges between driving operands and sampling `r`; legal range 1..15.
- FIFO_DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  OP_WIDTH  opcode.
- req_a  in  DATA_WIDTH  operand 1.
- req_b  in  DATA_WIDTH  operand 2.
- alu_op  out  OP_WIDTH  to ALU `op`.
- alu_a  out  DATA_WIDTH  to ALU `a`.
- alu_b  out  DATA_WIDTH  to ALU `b`.
- alu_r  in  DATA_WIDTH  from ALU `r`.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer pops head.
- rsp_op  out  OP_WIDTH  opcode of head entry.
- rsp_r  out  DATA_WIDTH  result of head entry.
- busy  out  1  high in SETTLE state.
- issued_cnt  out  16  number of accepted requests, wraps modulo 2^16.

Behaviour:
- Reset is synchronous: rst sampled high at a rising edge takes effect at that edge and overrides all other inputs.
  - State = IDLE; alu_op/alu_a/alu_b = 0; FIFO empty; rsp_valid = 0; rsp_op/rsp_r = 0; busy = 0; issued_cnt = 0; settle counter = 0.
  - A reset during SETTLE abandons the in-flight operation; no FIFO push occurs.
- req_ready is combinational: (state == IDLE) && (fifo_count < FIFO_DEPTH) && !rst.
- State IDLE:
  - On an edge with req_valid && req_ready:
    - register req_op/a/b onto alu_op/a/b;
    - load counter = SETTLE_CYCLES-1;
    - increment issued_cnt;
    - go to SETTLE.
  - Otherwise alu_* hold their last values and are never cleared between operations.
- State SETTLE:
  - busy = 1; req_ready = 0; alu_* held stable.
  - On each edge with counter != 0: decrement the counter.
  - On the edge with counter == 0: push {alu_op, alu_r} into the FIFO, then return to IDLE.
- Latency: request accepted at edge E0 → result sampled at edge E0+SETTLE_CYCLES → rsp_valid high after that edge if the FIFO was empty.
- Throughput: one request per SETTLE_CYCLES+1 cycles. req_ready is low in the IDLE-return cycle only if the FIFO is full.
- FIFO:
  - Show-ahead: rsp_op/rsp_r present the head while rsp_valid = 1.
  - Pop on an edge with rsp_valid && rsp_ready.
  - rsp_ready while empty is ignored.
  - rsp_op/rsp_r hold the last-popped value while empty.
- Space reservation: a request is accepted only when fifo_count < FIFO_DEPTH. Only one operation is in flight, so the push at the end of SETTLE always has room. Overflow is impossible by construction; assert it in simulation.
- Simultaneous push and pop: count unchanged, ordering preserved. Pointers wrap modulo FIFO_DEPTH.
- Full: req_ready stays low until a pop. The request becomes acceptable in the cycle after the pop edge.
- Request handshake: req_* must be stable while req_valid && !req_ready. The block samples them only at the accept edge.
- issued_cnt wraps 0xFFFF → 0x0000 with no flag.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst for 2 cycles, then release.
  - Required: all outputs 0, req_ready = 1 on the first post-reset cycle, rsp_valid = 0.
- Single op, SETTLE_CYCLES = 2, rsp_ready = 1 held:
  - Stimulus: req op = 4'h1, a = 32'h0000_0005, b = 32'h0000_0003, with the ALU model returning 32'h0000_0008.
  - Required: alu_* updated after E0; busy for 2 cycles; rsp_valid at E0+2 with rsp_op = 1, rsp_r = 8; issued_cnt = 1.
- Fill and block, FIFO_DEPTH = 4, rsp_ready = 0:
  - Stimulus: issue 5 back-to-back requests with a = 1..5.
  - Required: 4 accepted; req_ready stays low after the 4th completes; the 5th is accepted 1 cycle after the first pop; responses come out in order a = 1, 2, 3, 4, 5.
- Push/pop collision:
  - Stimulus: FIFO holds 1 entry; pop on the same edge that SETTLE pushes.
  - Required: count stays 1; the new head is the pushed entry.
- Reset mid-operation:
  - Stimulus: assert rst in the 2nd SETTLE cycle.
  - Required: no response ever appears; state returns to IDLE; alu_* = 0; issued_cnt = 0.
- Counter wrap:
  - Stimulus: preload via 65536 accepted requests (or force).
  - Required: issued_cnt reads 0x0000 after the 65536th accept, with no other side effects.
